// File: rtl/output_port_arbiter.sv
// Output port arbiter: round-robin selection among four input buffers, one flit in flight at a time.
// Defining ARB_PKT_LOCK_EN holds the grant on one requester until a tail flit (bit 14) is accepted.
module output_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_empty_i,
  input  logic [3:0]  req_valid_i,
  input  logic [63:0] req_data_i,
  output logic [3:0]  req_read_o,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [15:0] out_data_o,
  output logic [3:0]  grant_o,
  output logic        err_o,
  output logic [7:0]  fwd_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  read_q;
  logic [3:0]  grant_q;
  logic [1:0]  gidx_q;
  logic [1:0]  last_q;
  logic [1:0]  wait_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic        err_q;
  logic [7:0]  cnt_q;
`ifdef ARB_PKT_LOCK_EN
  logic        lock_q;
`endif

  logic        pick_found_s;
  logic [1:0]  pick_idx_s;
  logic [1:0]  cand_s;
  logic [15:0] sel_data_s;

  assign sel_data_s = req_data_i[{gidx_q, 4'b0000} +: 16];

  // Round-robin search beginning just after last_q; a held packet lock restricts it to the owner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 2'd0;
    cand_s       = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand_s = last_q + 2'(i);
      if (!pick_found_s && !req_empty_i[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
`ifdef ARB_PKT_LOCK_EN
    if (lock_q) begin
      pick_found_s = !req_empty_i[gidx_q];
      pick_idx_s   = gidx_q;
    end else begin
      pick_found_s = pick_found_s;
    end
`endif
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      read_q      <= 4'b0000;
      grant_q     <= 4'b0000;
      gidx_q      <= 2'd0;
      last_q      <= 2'd3;
      wait_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      read_q <= 4'b0000;
      case (state_q)
        IDLE: begin
          if (pick_found_s) begin
            grant_q <= 4'b0001 << pick_idx_s;
            read_q  <= 4'b0001 << pick_idx_s;
            gidx_q  <= pick_idx_s;
            wait_q  <= 2'd0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (req_valid_i[gidx_q]) begin
            out_data_q  <= sel_data_s;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end else if (wait_q == 2'd2) begin
            // Third silent cycle: flag the stuck buffer and drop ownership.
            err_q   <= 1'b1;
            grant_q <= 4'b0000;
            state_q <= IDLE;
`ifdef ARB_PKT_LOCK_EN
            lock_q  <= 1'b0;
`endif
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        SEND: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            cnt_q       <= cnt_q + 8'd1;
            last_q      <= gidx_q;
            state_q     <= IDLE;
`ifdef ARB_PKT_LOCK_EN
            lock_q      <= ~out_data_q[14];
            if (out_data_q[14]) begin
              grant_q <= 4'b0000;
            end
`else
            grant_q     <= 4'b0000;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_read_o  = read_q;
  assign grant_o     = grant_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign err_o       = err_q;
  assign fwd_count_o = cnt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: a buffer model answers reads one cycle later,
// expected flits are queued at stimulus time and checked by a monitor on every accepted flit.
module tb_output_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_empty_i;
  logic [3:0]  req_valid_i;
  logic [63:0] req_data_i;
  logic [3:0]  req_read_o;
  logic        out_ready_i;
  logic        out_valid_o;
  logic [15:0] out_data_o;
  logic [3:0]  grant_o;
  logic        err_o;
  logic [7:0]  fwd_count_o;

  output_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_empty_i (req_empty_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_read_o  (req_read_o),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .grant_o     (grant_o),
    .err_o       (err_o),
    .fwd_count_o (fwd_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  g;
  } exp_t;

  exp_t        sb[$];
  int          nvec  = 0;
  int          nfail = 0;
  logic [15:0] mem [0:3][0:63];
  int          wr   [4];
  int          rd   [4];
  bit          pend [4];
  bit          mute [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Buffer model: a read seen in one cycle yields valid+data in the following cycle.
  always @(negedge clk) begin
    for (int n = 0; n < 4; n++) begin
      req_valid_i[n] = 1'b0;
      if (pend[n] && !mute[n] && rd[n] != wr[n]) begin
        req_valid_i[n] = 1'b1;
        req_data_i[16*n +: 16] = mem[n][rd[n] % 64];
        rd[n] = rd[n] + 1;
      end
      pend[n] = req_read_o[n];
      req_empty_i[n] = (rd[n] == wr[n]);
    end
  end

  // Monitor: every flit accepted downstream must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_flit", {16'h0, out_data_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_data", {16'h0, out_data_o}, {16'h0, e.d});
        chk("sb_grant", {28'h0, grant_o}, {28'h0, e.g});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input int n, input logic [15:0] d);
    mem[n][wr[n] % 64] = d;
    wr[n] = wr[n] + 1;
  endtask

  task automatic expect_flit(input logic [15:0] d, input logic [3:0] g);
    exp_t e;
    e.d = d;
    e.g = g;
    sb.push_back(e);
  endtask

  task automatic wait_read(input int budget);
    int k = 0;
    while (req_read_o == 4'b0000 && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic wait_count(input logic [7:0] target, input int budget, input string nm);
    int k = 0;
    while (fwd_count_o != target && k < budget) begin
      step();
      k++;
    end
    chk(nm, {24'h0, fwd_count_o}, {24'h0, target});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int k;
    reset       = 1'b1;
    out_ready_i = 1'b1;
    req_empty_i = 4'b1111;
    req_valid_i = 4'b0000;
    req_data_i  = 64'h0;
    for (int n = 0; n < 4; n++) begin
      wr[n] = 0; rd[n] = 0; pend[n] = 1'b0; mute[n] = 1'b0;
    end

    // Reset state
    do_reset();
    chk("rst_read", {28'h0, req_read_o}, 32'h0);
    chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_data", {16'h0, out_data_o}, 32'h0);
    chk("rst_grant", {28'h0, grant_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_count", {24'h0, fwd_count_o}, 32'h0);

    // Single flit from buffer 0
    push(0, 16'h8001);
    expect_flit(16'h8001, 4'b0001);
    wait_read(20);
    chk("single_read", {28'h0, req_read_o}, 32'h1);
    chk("single_grant", {28'h0, grant_o}, 32'h1);
    step();
    chk("single_read_pulse", {28'h0, req_read_o}, 32'h0);
    wait_count(8'd1, 20, "single_count");

    // Round robin over four full buffers
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 4; n++) begin
        d = 16'h4000 + 16'(r * 16 + n);
        push(n, d);
        expect_flit(d, 4'b0001 << n);
      end
    end
    wait_count(8'd8, 200, "rr_count");
    step();
    step();
    chk("idle_grant", {28'h0, grant_o}, 32'h0);
    chk("idle_read", {28'h0, req_read_o}, 32'h0);
    chk("idle_valid", {31'h0, out_valid_o}, 32'h0);
    chk("idle_data", {16'h0, out_data_o}, 32'h0);

    // Backpressure in SEND
    do_reset();
    out_ready_i = 1'b0;
    push(2, 16'hC0A5);
    push(3, 16'h4033);
    expect_flit(16'hC0A5, 4'b0100);
    expect_flit(16'h4033, 4'b1000);
    k = 0;
    while (!out_valid_o && k < 20) begin
      step();
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", {31'h0, out_valid_o}, 32'h1);
      chk("stall_data", {16'h0, out_data_o}, 32'hC0A5);
      chk("stall_read", {28'h0, req_read_o}, 32'h0);
      step();
    end
    chk("stall_count", {24'h0, fwd_count_o}, 32'h0);
    out_ready_i = 1'b1;
    wait_count(8'd2, 40, "stall_release_count");

    // Read timeout on a silent buffer
    do_reset();
    mute[1] = 1'b1;
    push(1, 16'h4011);
    wait_read(20);
    chk("to_grant", {28'h0, grant_o}, 32'h2);
    step();
    step();
    chk("to_err_early", {31'h0, err_o}, 32'h0);
    chk("to_grant_held", {28'h0, grant_o}, 32'h2);
    mute[1] = 1'b0;
    push(2, 16'h4222);
    expect_flit(16'h4011, 4'b0010);
    expect_flit(16'h4222, 4'b0100);
    step();
    chk("to_err", {31'h0, err_o}, 32'h1);
    chk("to_grant_clear", {28'h0, grant_o}, 32'h0);
    wait_count(8'd2, 40, "to_after_count");
    chk("to_err_sticky", {31'h0, err_o}, 32'h1);

    // Packet lock vs independent arbitration
    do_reset();
    push(1, 16'h8000);
    push(1, 16'h0000);
    push(1, 16'h4000);
    push(2, 16'h4222);
`ifdef ARB_PKT_LOCK_EN
    expect_flit(16'h8000, 4'b0010);
    expect_flit(16'h0000, 4'b0010);
    expect_flit(16'h4000, 4'b0010);
    expect_flit(16'h4222, 4'b0100);
`else
    expect_flit(16'h8000, 4'b0010);
    expect_flit(16'h4222, 4'b0100);
    expect_flit(16'h0000, 4'b0010);
    expect_flit(16'h4000, 4'b0010);
`endif
    wait_count(8'd4, 100, "lock_count");

    // Reset during WAIT
    do_reset();
    mute[1] = 1'b1;
    push(1, 16'h4111);
    wait_read(20);
    chk("rw_grant", {28'h0, grant_o}, 32'h2);
    step();
    reset = 1'b1;
    step();
    chk("rw_read", {28'h0, req_read_o}, 32'h0);
    chk("rw_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rw_data", {16'h0, out_data_o}, 32'h0);
    chk("rw_grant_clear", {28'h0, grant_o}, 32'h0);
    chk("rw_err", {31'h0, err_o}, 32'h0);
    chk("rw_count", {24'h0, fwd_count_o}, 32'h0);
    reset = 1'b0;
    mute[1] = 1'b0;
    push(0, 16'h4100);
    expect_flit(16'h4100, 4'b0001);
    expect_flit(16'h4111, 4'b0010);
    wait_count(8'd2, 40, "rw_after_count");

    step();
    chk("sb_leftover", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
